pipeline_reg_chain: RTL

//  Parametrised chain of NUM_STAGES inter-stage pipeline registers (default IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/common_pkg.sv | 22 ++
 rtl/pipeline_reg_chain_pipe_slot.sv | 69 ++++++
 rtl/pipeline_reg_chain.sv | 139 +++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_pkg
// Description : Shared definitions for the pipeline register chain. Provides
//               the default PC width and the stage-slot indices used to
//               address stall_i, flush_i, stage_valid_o and stage_pc_o.
// Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

    localparam int XLEN = 32;

    // Slot index of each inter-stage register in the default 4-slot chain.
    typedef enum logic [1:0] {
        IF_ID  = 2'd0,
        ID_EX  = 2'd1,
        EX_MEM = 2'd2,
        MEM_WB = 2'd3
    } pipe_stage_e;

endpackage : common_pkg
`default_nettype wire

// File: rtl/pipeline_reg_chain_pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline register slot: valid bit, PC and opaque payload.
//               Sequencing decisions (move/feed/flush) are made by the chain.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               move_i        - slot content is replaced this cycle
//               feed_i        - upstream entry is handed to this slot
//               flush_i       - kill the slot and its incoming entry
//               pc_i/payload_i- incoming entry
//               valid_o/pc_o/payload_o - current slot content
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import common_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_i,
    input  logic                 feed_i,
    input  logic                 flush_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      pc_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 load_w;

    always_comb begin
        load_w    = feed_i & ~flush_i;
        valid_d   = valid_q;
        pc_d      = pc_q;
        payload_d = payload_q;
        if (move_i) begin
            valid_d = load_w;
        end
        // Data only captures real entries so bubbles do not toggle the bus.
        if (load_w) begin
            pc_d      = pc_i;
            payload_d = payload_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign payload_o = payload_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipeline_reg_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_reg_chain
// Description : Chain of NUM_STAGES pipeline register slots with valid/ready
//               flow control, per-slot stall and per-slot flush.
// Ports       : in_valid/in_ready/in_pc/in_payload   - upstream handshake
//               out_valid/out_ready/out_pc/out_payload - downstream handshake
//               stall_i/flush_i  - per-slot hold and kill requests
//               stage_valid_o/stage_pc_o - per-slot observation
//               hold_cnt_o/flush_cnt_o   - performance counters
// Config      : PIPE_PERF_CNT_EN - when defined, adds the two 32-bit
//               performance counter ports and their logic.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_reg_chain
    import common_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int XLEN       = common_pkg::XLEN,
    parameter int PAYLOAD_W  = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [NUM_STAGES-1:0]      stall_i,
    input  logic [NUM_STAGES-1:0]      flush_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [NUM_STAGES-1:0]      stage_valid_o,
    output logic [NUM_STAGES*XLEN-1:0] stage_pc_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]                hold_cnt_o,
    output logic [31:0]                flush_cnt_o
`endif
);

    logic [NUM_STAGES-1:0] valid_w;
    logic [NUM_STAGES-1:0] dn_w;
    logic [NUM_STAGES-1:0] leave_w;
    logic [NUM_STAGES-1:0] move_w;
    logic [NUM_STAGES-1:0] feed_w;
    logic [XLEN-1:0]       pc_w      [NUM_STAGES];
    logic [PAYLOAD_W-1:0]  payload_w [NUM_STAGES];
    logic [XLEN-1:0]       up_pc_w   [NUM_STAGES];
    logic [PAYLOAD_W-1:0]  up_pay_w  [NUM_STAGES];

    // Readiness ripples from the output end back to the input, so slots are
    // evaluated tail-first: a slot may move only if its successor moves.
    always_comb begin
        dn_w    = '0;
        leave_w = '0;
        move_w  = '0;
        feed_w  = '0;
        dn_w[NUM_STAGES-1]    = out_ready;
        leave_w[NUM_STAGES-1] = valid_w[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1]
                              & ~flush_i[NUM_STAGES-1] & dn_w[NUM_STAGES-1];
        move_w[NUM_STAGES-1]  = flush_i[NUM_STAGES-1] | ~valid_w[NUM_STAGES-1]
                              | leave_w[NUM_STAGES-1];
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            dn_w[k]    = move_w[k+1];
            leave_w[k] = valid_w[k] & ~stall_i[k] & ~flush_i[k] & dn_w[k];
            // A flushed slot always moves so upstream drains into it.
            move_w[k]  = flush_i[k] | ~valid_w[k] | leave_w[k];
        end
        feed_w[0] = in_valid & move_w[0];
        for (int k = 1; k < NUM_STAGES; k++) begin
            feed_w[k] = leave_w[k-1];
        end
    end

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
            if (k == 0) begin : g_head
                assign up_pc_w[k]  = in_pc;
                assign up_pay_w[k] = in_payload;
            end else begin : g_body
                assign up_pc_w[k]  = pc_w[k-1];
                assign up_pay_w[k] = payload_w[k-1];
            end

            pipe_slot #(
                .XLEN      (XLEN),
                .PAYLOAD_W (PAYLOAD_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .move_i    (move_w[k]),
                .feed_i    (feed_w[k]),
                .flush_i   (flush_i[k]),
                .pc_i      (up_pc_w[k]),
                .payload_i (up_pay_w[k]),
                .valid_o   (valid_w[k]),
                .pc_o      (pc_w[k]),
                .payload_o (payload_w[k])
            );

            assign stage_pc_o[k*XLEN +: XLEN] = pc_w[k];
        end
    endgenerate

    assign in_ready      = move_w[0];
    assign stage_valid_o = valid_w;
    assign out_valid     = valid_w[NUM_STAGES-1] & ~stall_i[NUM_STAGES-1]
                         & ~flush_i[NUM_STAGES-1];
    assign out_pc        = pc_w[NUM_STAGES-1];
    assign out_payload   = payload_w[NUM_STAGES-1];

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters wrap naturally at 32 bits.
    always_comb begin
        hold_cnt_d  = hold_cnt_q + {31'd0, in_valid & ~in_ready};
        flush_cnt_d = flush_cnt_q + {31'd0, |flush_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hold_cnt_o  = hold_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule : pipeline_reg_chain
`default_nettype wire
